// File: rtl/xor_nina_acc_ctrl.sv
// Masked XOR-fold sequencer: folds a run of `len` two-share operands into
// per-share accumulators, then offers the masked result on a valid/ready port.
module xor_nina_acc_ctrl #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a_0,
  input  logic [WIDTH-1:0] in_a_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c_0,
  output logic [WIDTH-1:0] out_c_1,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake rule on both ports: a transfer happens on a rising edge where
  // valid and ready are both high; the producer holds valid and data until then.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc_0, acc_0_nxt;
  logic [WIDTH-1:0] acc_1, acc_1_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc_0 <= '0;
      acc_1 <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc_0 <= acc_0_nxt;
      acc_1 <= acc_1_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Each share accumulator only ever sees its own share; no cross-domain term.
  always_comb begin
    state_nxt = state;
    acc_0_nxt = acc_0;
    acc_1_nxt = acc_1;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          acc_0_nxt = '0;
          acc_1_nxt = '0;
          if (len == '0) begin
            state_nxt = DONE;
          end else begin
            cnt_nxt   = len;
            state_nxt = ACC;
          end
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_0_nxt = acc_0 ^ in_a_0;
          acc_1_nxt = acc_1 ^ in_a_1;
          cnt_nxt   = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_0_nxt = '0;
          acc_1_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state == ACC) || (state == DONE);
  assign out_c_0   = acc_0;
  assign out_c_1   = acc_1;
  assign dbg_state = state;

endmodule
